output_fifo: RTL and testbench

Elastic output buffer sitting directly downstream of the MAC datapath/demux output port. It accepts the serialized result stream (`out_data`/`valid_out`) and drives the demux `out_ready` from its own not-full status. It presents a first-word-fall-through valid/ready stream to the consumer and tags the final element of each result vector. This decouples consumer backpressure from the accumulator stall logic, so the MAC array stalls only when the buffer is genuinely full.

---
 rtl/output_fifo.sv | 139 +++++++++++++
 tb/tb_output_fifo.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_fifo.sv
// ============================================================================
// output_fifo
// ----------------------------------------------------------------------------
// Elastic output buffer placed directly after the MAC demux output port.
// Accepts the serialized result stream, throttles the demux via in_ready
// (not-full), and presents a first-word-fall-through stream to the consumer.
// The final element of every MATRIX_ROW_LENGTH-word result vector is tagged
// with out_last. Tagging follows accepted pushes only.
//
// Handshake (both sides): a transfer happens on a rising clk edge exactly
// when valid && ready are both high in the cycle before that edge. valid is
// never conditioned on ready; the sender holds its word until the transfer.
//
// Optional feature macro: OUT_FIFO_PEAK_EN
//   When defined, adds output `peak`, the occupancy high-water mark since
//   the last reset.
//
// Ports:
//   clk        in   1                 single clock, posedge
//   reset      in   1                 synchronous, active-high
//   in_data    in   DATA_LENGTH       signed result word from the demux
//   in_valid   in   1                 in_data is valid
//   in_ready   out  1                 buffer not full (demux out_ready)
//   out_data   out  DATA_LENGTH       head word, 0 when empty
//   out_valid  out  1                 head word valid (buffer not empty)
//   out_ready  in   1                 consumer accepts head word
//   out_last   out  1                 head word closes its vector
//   peak       out  $clog2(DEPTH)+1   high-water mark (OUT_FIFO_PEAK_EN)
//   count      out  $clog2(DEPTH)+1   occupancy, 0..DEPTH
// ============================================================================
module output_fifo #(
    parameter int DATA_LENGTH       = 14,
    parameter int MATRIX_ROW_LENGTH = 8,
    parameter int DEPTH             = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic signed [DATA_LENGTH-1:0] in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic signed [DATA_LENGTH-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
`ifdef OUT_FIFO_PEAK_EN
    output logic [$clog2(DEPTH):0]        peak,
`endif
    output logic [$clog2(DEPTH):0]        count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int VW = (MATRIX_ROW_LENGTH > 1) ? $clog2(MATRIX_ROW_LENGTH) : 1;

    localparam logic [AW-1:0] PTR_MAX  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [VW-1:0] VCNT_MAX = VW'(MATRIX_ROW_LENGTH - 1);

    // Each entry is {last, data}.
    logic [DATA_LENGTH:0] r_mem [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [VW-1:0] r_vcnt;

    logic                 w_in_ready;
    logic                 w_out_valid;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_last;
    logic [CW-1:0]        w_count_next;
    logic [DATA_LENGTH:0] w_head;

    // Full/empty come from the registered count only; there is deliberately
    // no pass-through of a push when full, even if a pop happens that cycle.
    always_comb begin
        w_in_ready  = (r_count != CNT_FULL);
        w_out_valid = (r_count != '0);
        w_push      = in_valid && w_in_ready;
        w_pop       = w_out_valid && out_ready;
        w_last      = (r_vcnt == VCNT_MAX);
        w_head      = r_mem[r_rd_ptr];
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CW'(1);
            2'b01:   w_count_next = r_count - CW'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Pointers, occupancy and vector position.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vcnt   <= '0;
        end else begin
            r_count <= w_count_next;
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_MAX) ? '0 : r_wr_ptr + AW'(1);
                r_vcnt   <= w_last ? '0 : r_vcnt + VW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_MAX) ? '0 : r_rd_ptr + AW'(1);
            end
        end
    end

    // Storage array is intentionally not reset; occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= {w_last, in_data};
        end
    end

`ifdef OUT_FIFO_PEAK_EN
    logic [CW-1:0] r_peak;

    // Compare against next count so the mark tracks the edge-updated value.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_peak <= '0;
        end else if (w_count_next > r_peak) begin
            r_peak <= w_count_next;
        end
    end

    assign peak = r_peak;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_out_valid ? w_head[DATA_LENGTH-1:0] : '0;
    assign out_last  = w_out_valid ? w_head[DATA_LENGTH] : 1'b0;
    assign count     = r_count;

endmodule

// File: tb/tb_output_fifo.sv
// ============================================================================
// tb_output_fifo
// ----------------------------------------------------------------------------
// Self-checking bench for output_fifo. Inputs change 1 time unit after the
// rising edge; a negedge monitor records accepted pushes into an expected
// queue (with a bench-side vector counter for last tags) and compares every
// accepted pop against the queue head. Scenario tasks add inline checks.
// ============================================================================
module tb_output_fifo;

    localparam int DL    = 14;
    localparam int MRL   = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic signed [DL-1:0] in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DL-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic                 out_last;
    logic [CW-1:0]        count;
`ifdef OUT_FIFO_PEAK_EN
    logic [CW-1:0]        peak;
`endif

    output_fifo #(
        .DATA_LENGTH       (DL),
        .MATRIX_ROW_LENGTH (MRL),
        .DEPTH             (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
`ifdef OUT_FIFO_PEAK_EN
        .peak      (peak),
`endif
        .count     (count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int            checks   = 0;
    int            failures = 0;
    logic [DL:0]   exp_q[$];
    int            m_vcnt   = 0;

    always @(negedge clk) begin
        logic [DL:0] e;
        if (reset) begin
            exp_q.delete();
            m_vcnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_pop_empty got=%0d,%0d required=no_pop", out_last, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_data} !== e) begin
                        failures++;
                        $display("FAIL sb_data got last=%0d data=%0d required last=%0d data=%0d",
                                 out_last, out_data, e[DL], $signed(e[DL-1:0]));
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({(m_vcnt == MRL - 1), in_data});
                m_vcnt = (m_vcnt == MRL - 1) ? 0 : m_vcnt + 1;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (count == 0) break;
            tick();
        end
        checks++;
        if (count !== '0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_empty got count=%0d queued=%0d required 0", count, exp_q.size());
        end
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 ||
                out_last !== 1'b0 || count !== '0) begin
                failures++;
                $display("FAIL reset_idle got rdy=%0b vld=%0b data=%0d last=%0b cnt=%0d required 1 0 0 0 0",
                         in_ready, out_valid, out_data, out_last, count);
            end
        end
`ifdef OUT_FIFO_PEAK_EN
        checks++;
        if (peak !== '0) begin
            failures++;
            $display("FAIL peak_reset got=%0d required=0", peak);
        end
`endif
    endtask

    task automatic test_stream;
        logic signed [DL-1:0] v [8];
        v[0] = -14'sd3;  v[1] = 14'sd5;   v[2] = -14'sd7; v[3] = 14'sd12;
        v[4] = -14'sd100; v[5] = 14'sd0;  v[6] = -14'sd1; v[7] = 14'sd100;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== v[i] || out_last !== (i == 7)) begin
                failures++;
                $display("FAIL stream_word%0d got vld=%0b data=%0d last=%0b required 1 %0d %0b",
                         i, out_valid, out_data, out_last, v[i], (i == 7));
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (count !== '0) begin
            failures++;
            $display("FAIL stream_drained got=%0d required=0", count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_fill;
        logic signed [DL-1:0] w [20];
        int  idx;
        logic acc;
        for (int i = 0; i < 20; i++) w[i] = DL'(i * 311 - 3000);
        idx = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid = 1'b1;
            in_data  = w[idx];
            acc = in_ready;
            tick();
            if (acc) idx++;
            if (cyc == 14) begin
                checks++;
                if (in_ready !== 1'b1 || count !== CW'(15)) begin
                    failures++;
                    $display("FAIL fill_15 got rdy=%0b cnt=%0d required 1 15", in_ready, count);
                end
            end
            if (cyc >= 15) begin
                checks++;
                if (in_ready !== 1'b0 || count !== CW'(16)) begin
                    failures++;
                    $display("FAIL fill_full_c%0d got rdy=%0b cnt=%0d required 0 16", cyc, in_ready, count);
                end
            end
        end
`ifdef OUT_FIFO_PEAK_EN
        checks++;
        if (peak !== CW'(16)) begin
            failures++;
            $display("FAIL peak_fill got=%0d required=16", peak);
        end
`endif
        // Consumer opens up; upstream still holds words 17..20.
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && idx < 20; cyc++) begin
            in_valid = 1'b1;
            in_data  = w[idx];
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 20) begin
            failures++;
            $display("FAIL fill_upstream_done got=%0d required=20", idx);
        end
        drain();
    endtask

    task automatic test_full_simul;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = DL'($urandom_range(0, (1 << DL) - 1));
            tick();
        end
        checks++;
        if (in_ready !== 1'b0 || count !== CW'(16)) begin
            failures++;
            $display("FAIL full_before got rdy=%0b cnt=%0d required 0 16", in_ready, count);
        end
        in_valid  = 1'b1;
        in_data   = 14'sd77;
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (count !== CW'(15) || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_simul got cnt=%0d rdy=%0b required 15 1", count, in_ready);
        end
        tick();
        checks++;
        if (count !== CW'(15)) begin
            failures++;
            $display("FAIL full_hold got=%0d required=15", count);
        end
        drain();
    endtask

    task automatic test_steady;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DL'($urandom_range(0, (1 << DL) - 1));
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            in_data  = DL'($urandom_range(0, (1 << DL) - 1));
            tick();
            checks++;
            if (count !== CW'(3) || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL steady_c%0d got cnt=%0d vld=%0b required 3 1", i, count, out_valid);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid;
        // Position the vector counter so nine held words leave it at 5.
        out_ready = 1'b1;
        for (int k = 0; k < MRL && m_vcnt != 4; k++) begin
            in_valid = 1'b1;
            in_data  = DL'($urandom_range(0, (1 << DL) - 1));
            tick();
        end
        drain();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = DL'($urandom_range(0, (1 << DL) - 1));
            tick();
        end
        checks++;
        if (count !== CW'(9) || m_vcnt != 5) begin
            failures++;
            $display("FAIL mid_setup got cnt=%0d vcnt=%0d required 9 5", count, m_vcnt);
        end
        // Reset wins over a simultaneous push and pop.
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 14'sd1234;
        out_ready = 1'b1;
        tick();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (count !== '0 || out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset got cnt=%0d vld=%0b data=%0d rdy=%0b required 0 0 0 1",
                     count, out_valid, out_data, in_ready);
        end
`ifdef OUT_FIFO_PEAK_EN
        checks++;
        if (peak !== '0) begin
            failures++;
            $display("FAIL peak_mid_reset got=%0d required=0", peak);
        end
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = DL'(i * 5 - 20);
            tick();
            checks++;
            if (out_last !== (i == 7)) begin
                failures++;
                $display("FAIL mid_last_w%0d got=%0b required=%0b", i, out_last, (i == 7));
            end
        end
        drain();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_stream();
        test_fill();
        test_full_simul();
        test_steady();
        test_reset_mid();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
